// File: rtl/pixel_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package  : pixel_write_arbiter_pkg
// Desc     : Shared game constants: requester indices, pixel field widths,
//            arbiter state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package pixel_write_arbiter_pkg;

    localparam int NUM_REQ  = 6;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 3;

    localparam int REQ_SCREEN = 0;
    localparam int REQ_PADDLE = 1;
    localparam int REQ_LEVEL  = 2;
    localparam int REQ_BALL   = 3;
    localparam int REQ_SCORE  = 4;
    localparam int REQ_LIFE   = 5;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } arbState_t;

    // A single requester still needs a 1-bit pointer to keep port widths legal.
    function automatic int ptrWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_write_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : pixel_write_arbiter_rr_pick
// Desc     : Combinational rotate-priority selector; returns the first set
//            request at or after ptr (with wrap) as a one-hot vector.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_write_arbiter_rr_pick #(
    parameter int N     = 6,
    parameter int PTR_W = 3
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     pick
);

    localparam logic [PTR_W:0] c_N = (PTR_W + 1)'(N);

    logic [PTR_W:0]   w_sum;
    logic [PTR_W-1:0] w_idx;
    logic             w_found;

    always_comb begin
        pick    = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int i = 0; i < N; i++) begin
            w_sum = {1'b0, ptr} + (PTR_W + 1)'(i);
            if (w_sum >= c_N) begin
                w_sum = w_sum - c_N;
            end
            w_idx = w_sum[PTR_W-1:0];
            if (!w_found && req[w_idx]) begin
                pick[w_idx] = 1'b1;
                w_found     = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pixel_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pixel_write_arbiter
// Desc     : Round-robin, burst-granular arbiter sharing the framebuffer write
//            port among the draw engines; registered plot outputs.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_write_arbiter #(
    parameter int NUM_REQ  = pixel_write_arbiter_pkg::NUM_REQ,
    parameter int X_W      = pixel_write_arbiter_pkg::X_W,
    parameter int Y_W      = pixel_write_arbiter_pkg::Y_W,
    parameter int COLOUR_W = pixel_write_arbiter_pkg::COLOUR_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         hold,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ-1:0]           req_last,
    input  logic [NUM_REQ*X_W-1:0]       req_x,
    input  logic [NUM_REQ*Y_W-1:0]       req_y,
    input  logic [NUM_REQ*COLOUR_W-1:0]  req_colour,
    output logic [NUM_REQ-1:0]           grant,
    output logic [NUM_REQ-1:0]           ack,
    output logic [NUM_REQ-1:0]           done,
    output logic [X_W-1:0]               vga_x,
    output logic [Y_W-1:0]               vga_y,
    output logic [COLOUR_W-1:0]          vga_colour,
    output logic                         vga_plot,
    output logic [15:0]                  pixel_count
);
    import pixel_write_arbiter_pkg::*;

    localparam int PTR_W = ptrWidth(NUM_REQ);

    arbState_t           r_state,  w_stateNext;
    logic [PTR_W-1:0]    r_ptr,    w_ptrNext;
    logic [NUM_REQ-1:0]  r_grant,  w_grantNext;
    logic [NUM_REQ-1:0]  r_done,   w_doneNext;
    logic [X_W-1:0]      r_x,      w_xNext;
    logic [Y_W-1:0]      r_y,      w_yNext;
    logic [COLOUR_W-1:0] r_colour, w_colourNext;
    logic                r_plot,   w_plotNext;
    logic [15:0]         r_count,  w_countNext;

    logic [NUM_REQ-1:0]  w_pick;
    logic [NUM_REQ-1:0]  w_ack;
    logic                w_accept;
    logic                w_acceptLast;
    logic [X_W-1:0]      w_selX;
    logic [Y_W-1:0]      w_selY;
    logic [COLOUR_W-1:0] w_selColour;
    logic [PTR_W-1:0]    w_gIdx;
    logic [PTR_W-1:0]    w_ptrWrap;

    pixel_write_arbiter_rr_pick #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_rrPick (
        .req  (req),
        .ptr  (r_ptr),
        .pick (w_pick)
    );

    // Grant is one-hot, so an OR-style mux over the granted slice suffices.
    always_comb begin
        w_selX      = '0;
        w_selY      = '0;
        w_selColour = '0;
        w_gIdx      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i]) begin
                w_selX      = req_x[i*X_W +: X_W];
                w_selY      = req_y[i*Y_W +: Y_W];
                w_selColour = req_colour[i*COLOUR_W +: COLOUR_W];
                w_gIdx      = PTR_W'(i);
            end
        end
    end

    assign w_ack        = (r_state == XFER) ? (r_grant & req & {NUM_REQ{~hold}}) : '0;
    assign w_accept     = |w_ack;
    assign w_acceptLast = |(w_ack & req_last);
    assign w_ptrWrap    = (w_gIdx == PTR_W'(NUM_REQ - 1)) ? '0 : w_gIdx + PTR_W'(1);

    always_comb begin
        w_stateNext  = r_state;
        w_ptrNext    = r_ptr;
        w_grantNext  = r_grant;
        w_doneNext   = '0;
        w_xNext      = r_x;
        w_yNext      = r_y;
        w_colourNext = r_colour;
        w_plotNext   = 1'b0;
        w_countNext  = r_count;
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_grantNext = w_pick;
                    w_countNext = '0;
                    w_stateNext = XFER;
                end
            end
            XFER: begin
                if (w_accept) begin
                    w_plotNext   = 1'b1;
                    w_xNext      = w_selX;
                    w_yNext      = w_selY;
                    w_colourNext = w_selColour;
                    w_countNext  = (r_count == 16'hFFFF) ? r_count : r_count + 16'd1;
                    if (w_acceptLast) begin
                        w_doneNext  = r_grant;
                        w_grantNext = '0;
                        w_stateNext = IDLE;
                        w_ptrNext   = w_ptrWrap;
                    end
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_grant  <= '0;
            r_done   <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
            r_plot   <= 1'b0;
            r_count  <= '0;
        end else begin
            r_state  <= w_stateNext;
            r_ptr    <= w_ptrNext;
            r_grant  <= w_grantNext;
            r_done   <= w_doneNext;
            r_x      <= w_xNext;
            r_y      <= w_yNext;
            r_colour <= w_colourNext;
            r_plot   <= w_plotNext;
            r_count  <= w_countNext;
        end
    end

    assign grant       = r_grant;
    assign ack         = w_ack;
    assign done        = r_done;
    assign vga_x       = r_x;
    assign vga_y       = r_y;
    assign vga_colour  = r_colour;
    assign vga_plot    = r_plot;
    assign pixel_count = r_count;

endmodule
`default_nettype wire

// File: doc/pixel_write_arbiter.md
# pixel_write_arbiter

Shares the single framebuffer write port among the game's draw engines (background, paddle, level bricks, ball, score, lives). Each engine raises a request and streams pixels. The arbiter grants one engine at a time for a whole burst, round-robin, and drives registered plot signals to the VGA adapter. It sits between the draw engines and the VGA adapter, beneath the main game controller. That controller still decides when each engine is enabled.

## Interface
Parameters:
- NUM_REQ, 6, number of requesting draw engines (1..8)
- X_W, 8, x-coordinate width
- Y_W, 7, y-coordinate width
- COLOUR_W, 3, colour width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- hold  in  1  pauses pixel acceptance; the grant is kept
- req  in  NUM_REQ  per-engine request, held high for the whole burst
- req_last  in  NUM_REQ  marks the final pixel of that engine's burst
- req_x  in  NUM_REQ*X_W  packed x coordinates; engine i uses slice i
- req_y  in  NUM_REQ*Y_W  packed y coordinates
- req_colour  in  NUM_REQ*COLOUR_W  packed colours
- grant  out  NUM_REQ  one-hot, registered; all-zero when idle
- ack  out  NUM_REQ  pixel accepted this cycle (combinational)
- done  out  NUM_REQ  one-cycle registered pulse, one cycle after the last pixel is accepted
- vga_x  out  X_W  registered x coordinate
- vga_y  out  Y_W  registered y coordinate
- vga_colour  out  COLOUR_W  registered colour
- vga_plot  out  1  registered write strobe
- pixel_count  out  16  pixels accepted in the current burst; saturates at 16'hFFFF

## Operation
- State machine states: IDLE, XFER.
- Reset values: state=IDLE, ptr=0, grant=0, done=0, vga_x/y/colour=0, vga_plot=0, pixel_count=0.
- IDLE:
  - If any req bit is high, pick the first set bit scanning ptr, ptr+1, … with wrap.
  - Register grant to that bit, clear pixel_count, go to XFER.
  - If no req bit is high, stay in IDLE with grant=0.
- XFER, engine g granted:
  - ack[g] = req[g] & ~hold; all other ack bits are 0.
  - On an accept cycle, slice g of x/y/colour is registered to vga_* with vga_plot=1, and pixel_count increments (saturating).
  - On a non-accept cycle, vga_plot=0 and vga_x/y/colour hold their previous values.
  - On an accept cycle with req_last[g]=1: next cycle done[g]=1, grant=0, state=IDLE, ptr = g+1 (wrapping NUM_REQ-1 → 0).
- If req[g] drops mid-burst, the grant is held. No timeout; the engine must finish its own burst.
- req_last is ignored unless it coincides with an accept.
- Requests from non-granted engines are only sampled in IDLE. They are never dropped; engines keep req high until granted.

## Timing
- Latency from req rising in IDLE to grant: 1 cycle. The first pixel can be accepted on the cycle grant is visible.
- Pixel latency: accept in cycle n → vga_plot/vga_x/vga_y/vga_colour valid in cycle n+1.
- Throughput: one pixel per clock while req & ~hold.
- Burst turnaround: last accept in cycle n → done and IDLE in n+1 → next grant in n+2.
- Minimum gap between bursts is 1 plot-free cycle.
- A single-pixel burst (req_last on the first accept) is legal.
- hold asserted in the same cycle as req_last: no accept, and the burst stays open.
- reset asserted mid-burst: all outputs return to their reset values next cycle, and the pending last pixel is not plotted.
- NUM_REQ=1: ptr stays at 0 and the arbiter degenerates to a pass-through with a 1-cycle grant delay.

## Structure
- The shared game package holds NUM_REQ and the requester index constants (REQ_SCREEN=0, REQ_PADDLE=1, REQ_LEVEL=2, REQ_BALL=3, REQ_SCORE=4, REQ_LIFE=5). Draw engines and the game controller reference these constants.
- Coordinate and colour widths live in the same package.
- One sub-module: rr_pick.
  - Combinational rotate-priority selector: inputs req and ptr, output a one-hot result.
  - Instantiated once; reusable elsewhere.

## Test plan
- Single requester, burst of 4 pixels: req[1] with coords (10,20)…(13,20) and colour 3'b101.
  - grant=6'b000010 one cycle after req.
  - vga_plot high for 4 consecutive cycles, each one cycle after its ack.
  - done[1] pulses once; pixel_count reaches 4.
- Simultaneous requests req=6'b101001 from reset (ptr=0):
  - Grant order is 0, 3, 5.
  - After 5 the pointer wraps; a new req[0] is served before a re-raised req[5].
- hold for 3 cycles mid-burst of 8 pixels:
  - ack and vga_plot stay 0 for exactly 3 cycles.
  - grant is unchanged; all 8 pixels appear in order.
- Single-pixel burst on req[4], req_last high on the first accept:
  - Exactly one vga_plot, done[4] one cycle later, state back to IDLE.
- Reset asserted during the third pixel of a burst:
  - Next cycle grant=0, vga_plot=0, pixel_count=0.
  - A re-raised req[2] is granted via ptr=0 ordering.
- req[g] drops for 2 cycles mid-burst:
  - Grant is held, no plots during the gap, burst completes normally.
